// File: rtl/pe_dot_ctrl.sv
// Dot-product sequencer: streams ifmap/weight pairs from two read buffers into one int8 PE,
// accumulates the per-term results and hands back one 32-bit sum per job.
module pe_dot_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  // job dispatch
  input  logic                     start,
  input  logic        [LEN_W-1:0]  len,
  input  logic        [ADDR_W-1:0] ifmap_base,
  input  logic        [ADDR_W-1:0] weight_base,
  input  logic signed [31:0]       bias,
  output logic                     busy,
  // operand buffers
  output logic                     ifmap_rd,
  output logic                     weight_rd,
  output logic        [ADDR_W-1:0] ifmap_addr,
  output logic        [ADDR_W-1:0] weight_addr,
  input  logic signed [7:0]        ifmap_rdata,
  input  logic signed [7:0]        weight_rdata,
  // PE
  output logic signed [7:0]        pe_ifmap,
  output logic signed [7:0]        pe_weight,
  output logic signed [31:0]       pe_bias,
  output logic                     pe_en,
  input  logic signed [31:0]       pe_opsum,
  input  logic                     pe_valid,
  // result
  output logic signed [31:0]       res_data,
  output logic                     res_valid,
  input  logic                     res_ready
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

  state_e                    state_q;
  logic        [LEN_W-1:0]   len_q;
  logic        [ADDR_W-1:0]  ifmap_base_q;
  logic        [ADDR_W-1:0]  weight_base_q;
  logic signed [31:0]        bias_q;
  logic        [31:0]        acc_q;
  logic        [LEN_W-1:0]   issue_q;
  logic        [LEN_W-1:0]   rcv_q;
  logic                      rd_q;
  logic        [ADDR_W-1:0]  ifmap_addr_q;
  logic        [ADDR_W-1:0]  weight_addr_q;
  logic                      pe_en_q;
  logic                      pe_first_q;
  logic                      res_valid_q;
  logic        [31:0]        res_data_q;

  logic                      accept;
  logic        [31:0]        acc_sum;
  logic        [LEN_W-1:0]   rcv_inc;

  always_comb begin
    accept  = pe_valid && ((state_q == StFetch) || (state_q == StDrain));
    acc_sum = acc_q + pe_opsum;
    rcv_inc = rcv_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      len_q         <= '0;
      ifmap_base_q  <= '0;
      weight_base_q <= '0;
      bias_q        <= '0;
      acc_q         <= '0;
      issue_q       <= '0;
      rcv_q         <= '0;
      rd_q          <= 1'b0;
      ifmap_addr_q  <= '0;
      weight_addr_q <= '0;
      pe_en_q       <= 1'b0;
      pe_first_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      // PE feed trails the read strobe by the buffer's one-cycle read latency.
      pe_en_q    <= rd_q;
      pe_first_q <= rd_q && (issue_q == LEN_W'(1));

      if (accept) begin
        acc_q <= acc_sum;
        rcv_q <= rcv_inc;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q         <= len;
            ifmap_base_q  <= ifmap_base;
            weight_base_q <= weight_base;
            bias_q        <= bias;
            acc_q         <= '0;
            rcv_q         <= '0;
            if (len != '0) begin
              state_q       <= StFetch;
              rd_q          <= 1'b1;
              ifmap_addr_q  <= ifmap_base;
              weight_addr_q <= weight_base;
              issue_q       <= LEN_W'(1);
            end else begin
              state_q     <= StOut;
              issue_q     <= '0;
              res_valid_q <= 1'b1;
              res_data_q  <= bias;
            end
          end
        end
        StFetch: begin
          // issue_q counts reads already on the bus; equal to len means the last one is out.
          if (issue_q == len_q) begin
            rd_q    <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_q          <= 1'b1;
            ifmap_addr_q  <= ifmap_base_q + ADDR_W'(issue_q);
            weight_addr_q <= weight_base_q + ADDR_W'(issue_q);
            issue_q       <= issue_q + LEN_W'(1);
          end
        end
        StDrain: begin
          if (accept && (rcv_inc == len_q)) begin
            state_q     <= StOut;
            res_valid_q <= 1'b1;
            res_data_q  <= acc_sum;
          end else if (!accept && (rcv_q == len_q)) begin
            state_q     <= StOut;
            res_valid_q <= 1'b1;
            res_data_q  <= acc_q;
          end
        end
        StOut: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    ifmap_rd    = rd_q;
    weight_rd   = rd_q;
    ifmap_addr  = ifmap_addr_q;
    weight_addr = weight_addr_q;
    pe_en       = pe_en_q;
    pe_ifmap    = pe_en_q ? ifmap_rdata : '0;
    pe_weight   = pe_en_q ? weight_rdata : '0;
    pe_bias     = pe_first_q ? bias_q : '0;
    res_valid   = res_valid_q;
    res_data    = res_data_q;
  end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// Bench for pe_dot_ctrl: behavioural buffers and PE around the DUT, results checked
// against a plain-arithmetic dot-product model and the cycle timing of each job.
module tb_pe_dot_ctrl;
  localparam int AW = 12;
  localparam int LW = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic        [LW-1:0] len;
  logic        [AW-1:0] ifmap_base, weight_base;
  logic signed [31:0]   bias;
  logic                 busy;
  logic                 ifmap_rd, weight_rd;
  logic        [AW-1:0] ifmap_addr, weight_addr;
  logic signed [7:0]    ifmap_rdata, weight_rdata;
  logic signed [7:0]    pe_ifmap, pe_weight;
  logic signed [31:0]   pe_bias;
  logic                 pe_en;
  logic signed [31:0]   pe_opsum;
  logic                 pe_valid;
  logic signed [31:0]   res_data;
  logic                 res_valid;
  logic                 res_ready;

  logic signed [7:0] imem [4096];
  logic signed [7:0] wmem [4096];
  bit                force_en;
  logic [31:0]       force_val;

  int checks = 0;
  int errors = 0;

  pe_dot_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .ifmap_base(ifmap_base), .weight_base(weight_base), .bias(bias), .busy(busy),
    .ifmap_rd(ifmap_rd), .weight_rd(weight_rd),
    .ifmap_addr(ifmap_addr), .weight_addr(weight_addr),
    .ifmap_rdata(ifmap_rdata), .weight_rdata(weight_rdata),
    .pe_ifmap(pe_ifmap), .pe_weight(pe_weight), .pe_bias(pe_bias), .pe_en(pe_en),
    .pe_opsum(pe_opsum), .pe_valid(pe_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Single-port buffers with one-cycle read latency.
  always_ff @(posedge clk) begin
    ifmap_rdata  <= ifmap_rd ? imem[ifmap_addr] : 8'sd0;
    weight_rdata <= weight_rd ? wmem[weight_addr] : 8'sd0;
  end

  // PE: opsum = a*w + bias, valid one cycle after pe_en; force_en injects a fixed opsum.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_valid <= 1'b0;
      pe_opsum <= '0;
    end else begin
      pe_valid <= pe_en;
      pe_opsum <= force_en ? force_val : int'(pe_ifmap) * int'(pe_weight) + pe_bias;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rd"}, {30'd0, ifmap_rd, weight_rd}, 0);
    check({tag, "_addr"}, {8'd0, ifmap_addr, weight_addr}, 0);
    check({tag, "_pe"}, {15'd0, pe_en, pe_ifmap, pe_weight}, 0);
    check({tag, "_pe_bias"}, pe_bias, 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  task automatic run_job(input string tag, input int n, input logic [AW-1:0] ib,
                         input logic [AW-1:0] wb, input logic [31:0] b, input int stall,
                         input bit pulses, output logic [31:0] result);
    logic [31:0] expv, res_val, bias_at2;
    logic [AW-1:0] ia, wa;
    int rd_cnt, en_cnt, first_rd, last_rd, first_en, last_en, res_cyc;
    int addr_err, gate_err, strobe_err, busy_err, stable_err, idle_err;
    bit done;
    // reference: bias plus the sum of products, wrapping mod 2^32
    if (force_en) expv = 32'(n) * force_val;
    else begin
      expv = b;
      for (int k = 0; k < n; k++) begin
        ia = ib + AW'(k);
        wa = wb + AW'(k);
        expv = expv + 32'(int'(imem[ia]) * int'(wmem[wa]));
      end
    end
    rd_cnt = 0; en_cnt = 0; first_rd = 0; last_rd = 0; first_en = 0; last_en = 0;
    res_cyc = 0; addr_err = 0; gate_err = 0; strobe_err = 0; busy_err = 0;
    stable_err = 0; idle_err = 0; done = 0; res_val = 0; bias_at2 = 0;
    result = 'x;

    @(negedge clk);
    start = 1'b1; len = LW'(n); ifmap_base = ib; weight_base = wb; bias = b; res_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= n + stall + 40 && !done; c++) begin
      @(negedge clk);
      start = pulses && (c == 2 || c == n + 4);
      if (res_cyc != 0 && c == res_cyc + stall + 1) begin
        res_ready = 1'b0;
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_valid_after"}, 32'(res_valid), 0);
        done = 1;
      end else begin
        if (ifmap_rd !== weight_rd) strobe_err++;
        if (ifmap_rd) begin
          if (rd_cnt == 0) first_rd = c;
          last_rd = c;
          if (ifmap_addr !== ib + AW'(rd_cnt) || weight_addr !== wb + AW'(rd_cnt)) addr_err++;
          rd_cnt++;
        end
        if (pe_en) begin
          if (en_cnt == 0) first_en = c;
          last_en = c;
          en_cnt++;
        end else if (pe_ifmap !== 0 || pe_weight !== 0) gate_err++;
        if (c == 2) bias_at2 = pe_bias;
        else if (pe_bias !== 0) gate_err++;
        if (busy !== 1'b1) busy_err++;
        if (res_valid) begin
          if (res_cyc == 0) begin
            res_cyc = c;
            res_val = res_data;
          end else if (res_data !== res_val) stable_err++;
          if (c == res_cyc + stall) res_ready = 1'b1;
        end
      end
    end
    start = 1'b0;
    res_ready = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    result = res_val;
    check({tag, "_latency"}, 32'(res_cyc), (n == 0) ? 32'd1 : 32'(n + 3));
    check({tag, "_res_data"}, res_val, expv);
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'(n));
    check({tag, "_en_count"}, 32'(en_cnt), 32'(n));
    check({tag, "_addr_seq"}, 32'(addr_err), 0);
    check({tag, "_gating"}, 32'(gate_err), 0);
    check({tag, "_strobes"}, 32'(strobe_err), 0);
    check({tag, "_busy"}, 32'(busy_err), 0);
    check({tag, "_stable"}, 32'(stable_err), 0);
    if (n > 0) begin
      check({tag, "_rd_window"}, {first_rd[15:0], last_rd[15:0]}, {16'd1, 16'(n)});
      check({tag, "_en_window"}, {first_en[15:0], last_en[15:0]}, {16'd2, 16'(n + 1)});
      check({tag, "_pe_bias"}, bias_at2, b);
    end
    if (pulses) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (busy !== 1'b0 || res_valid !== 1'b0 || ifmap_rd !== 1'b0) idle_err++;
      end
      check({tag, "_no_queued_job"}, 32'(idle_err), 0);
    end
  endtask

  task automatic load_tp(input logic [AW-1:0] ib, input logic [AW-1:0] wb);
    imem[ib] = 8'sd1; imem[ib + 12'd1] = 8'sd2; imem[ib + 12'd2] = 8'sd3;
    wmem[wb] = 8'sd4; wmem[wb + 12'd1] = 8'sd5; wmem[wb + 12'd2] = 8'sd6;
  endtask

  initial begin
    logic [31:0] r;
    int n, st;
    logic [AW-1:0] ib, wb;
    for (int i = 0; i < 4096; i++) begin
      imem[i] = 8'($urandom);
      wmem[i] = 8'($urandom);
    end
    force_en = 0; force_val = '0;
    rst = 1'b1; start = 1'b0; len = '0; ifmap_base = '0; weight_base = '0; bias = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    load_tp(12'h100, 12'h200);
    run_job("tp_basic", 3, 12'h100, 12'h200, 32'd10, 0, 0, r);
    check("tp_basic_42", r, 32'd42);

    run_job("len0", 0, 12'h000, 12'h000, 32'hFFFF_FFF9, 0, 0, r);
    check("len0_value", r, 32'hFFFF_FFF9);

    run_job("backpressure", 2, 12'h300, 12'h340, 32'($urandom), 5, 1, r);

    run_job("wrap_addr", 4, 12'hFFE, 12'h7FF, 32'($urandom), 0, 0, r);

    for (int j = 0; j < 6; j++) begin
      n  = $urandom_range(1, 20);
      st = $urandom_range(0, 3);
      ib = AW'($urandom);
      wb = AW'($urandom);
      run_job("random", n, ib, wb, 32'($urandom), st, 0, r);
    end

    force_en = 1; force_val = 32'h7000_0000;
    run_job("acc_wrap", 5, 12'h010, 12'h020, 32'd3, 1, 0, r);
    check("acc_wrap_value", r, 32'h3000_0000);
    force_en = 0;

    for (int i = 0; i < 1023; i++) begin
      imem[i] = -8'sd128;
      wmem[i] = -8'sd128;
    end
    run_job("long", 1023, 12'h000, 12'h000, 32'hFFFF_FFFF, 0, 0, r);
    check("long_value", r, 32'd16760831);

    // reset in cycle 3 of a len=8 job
    @(negedge clk);
    start = 1'b1; len = 10'd8; ifmap_base = 12'h040; weight_base = 12'h080; bias = 32'd99;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    load_tp(12'h100, 12'h200);
    run_job("after_rst", 3, 12'h100, 12'h200, 32'd10, 0, 0, r);
    check("after_rst_42", r, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_dot_ctrl.md
# pe_dot_ctrl

Sequencer that drives a single int8 multiply-plus-bias PE through an N-term dot product. It fetches ifmap/weight operand pairs from two single-port read buffers and streams them into the PE. It accumulates the PE's per-term results and returns one 32-bit sum per job over a valid/ready result port. It sits between the job dispatcher (start/len/base addresses) and one PE instance.

## Interface
- ADDR_W, 12, operand buffer address width
- LEN_W, 10, width of job length (max terms 2^LEN_W-1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- len  in  LEN_W  number of terms; sampled with start
- ifmap_base  in  ADDR_W  first ifmap address; sampled with start
- weight_base  in  ADDR_W  first weight address; sampled with start
- bias  in  32 signed  job bias; sampled with start
- busy  out  1  high whenever state != IDLE
- ifmap_rd / weight_rd  out  1  read strobes (driven identically)
- ifmap_addr / weight_addr  out  ADDR_W  read addresses
- ifmap_rdata / weight_rdata  in  8 signed  read data, valid exactly 1 cycle after the strobe
- pe_ifmap / pe_weight  out  8 signed  PE operands
- pe_bias  out  32 signed  PE bias input
- pe_en  out  1  PE enable
- pe_opsum  in  32 signed  PE result
- pe_valid  in  1  PE result valid (1 cycle after pe_en)
- res_data  out  32 signed  job result
- res_valid  out  1  result valid
- res_ready  in  1  result accepted

## Operation
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE: start=1 latches len, both bases and bias. It clears the accumulator and the issue/receive counters. Next state is FETCH if len!=0. If len==0, next state is OUT with res_data=bias.
- FETCH: one read pair per cycle. Cycle k (k=0..len-1) asserts both rd strobes with addr = base + k mod 2^ADDR_W. Next state is DRAIN after the read with k=len-1.
- The PE feed is a 1-cycle-delayed copy of the rd strobe and drives pe_en. pe_ifmap and pe_weight pass through ifmap_rdata and weight_rdata combinationally.
- pe_bias = latched bias on the pe_en cycle of term 0, and 0 on every other cycle.
- When pe_en=0, pe_ifmap, pe_weight and pe_bias are 0.
- The accumulator adds pe_opsum on every cycle with pe_valid=1 while state is FETCH or DRAIN. pe_valid is ignored in IDLE and OUT.
- Sum is 32-bit two's complement, wrapping on overflow, no saturation.
- The receive counter increments on each accepted pe_valid.
- DRAIN: waits until the receive count equals len. It then moves to OUT with res_data = accumulator, including the final addition.
- OUT: res_valid=1 and res_data held stable until res_valid&&res_ready. On that cycle next state is IDLE.
- start is ignored in FETCH, DRAIN and OUT, and is not queued.
- Reset values: busy=0, rd strobes=0, addresses=0, pe_en=0, pe_ifmap=0, pe_weight=0, pe_bias=0, res_valid=0, res_data=0, accumulator=0, counters=0, state=IDLE.
- Reset mid-job aborts the job and discards partial sums. The PE shares rst, so no stale pe_valid follows.

## Timing
- Start accepted at edge E0; cycle n means n cycles after E0.
- Read strobes are high in cycles 1..len.
- pe_en is high in cycles 2..len+1.
- pe_valid is high in cycles 3..len+2.
- res_valid rises in cycle len+3, so latency from start to res_valid is len+3.
- len==0: res_valid in cycle 1; no read strobes and no pe_en.
- Throughput: one term per cycle, with no bubbles inside a job.
- Back-to-back jobs: the earliest start after a transfer is sampled the cycle after the res_valid&&res_ready cycle, i.e. once busy=0.
- busy rises in cycle 1 and falls the cycle after the result transfer.

## Test plan
- len=3, ifmap=[1,2,3], weight=[4,5,6], bias=10: reads in cycles 1-3, pe_bias=10 only in cycle 2, res_valid in cycle 6 with res_data=42.
- len=0, bias=-7: res_valid in cycle 1 with res_data=0xFFFFFFF9; rd strobes and pe_en never assert.
- Result backpressure: len=2 with res_ready held low 5 cycles after res_valid. res_data stays stable and busy stays high. start pulses during the job are ignored and no second job runs. After the transfer, busy=0 the next cycle.
- Address wrap, ADDR_W=12: ifmap_base=0xFFE, weight_base=0x7FF, len=4. ifmap_addr sequence is FFE, FFF, 000, 001; weight_addr sequence is 7FF, 800, 801, 802.
- Signed/long: len=1023, all operands -128, bias=-1: res_data=16760831 in cycle 1026. Separately, accumulator wrap is checked with a forced pe_opsum stream summing past 2^31 and compared against a mod-2^32 model.
- rst asserted in cycle 3 of a len=8 job: the next cycle all outputs are at reset values and busy=0. A following job with len=3, ifmap=[1,2,3], weight=[4,5,6], bias=10 returns 42 with the same timing as the first scenario.
